l1_req_arb: RTL and testbench

//  Shares the single L1 memory-access path between the L1I and L1D miss/uncached requesters.

---
 rtl/l1_arb_pkg.sv | 38 +++
 rtl/l1_arb_pick.sv | 67 ++++++
 rtl/l1_req_arb.sv | 132 +++++++++++++
 tb/tb_l1_req_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_arb_pkg.sv
// Shared types for the L1 request arbiter: FSM states, source encoding and the request record.
// Optional build macro L1_ARB_RR_EN (strict round-robin) is consumed by l1_arb_pick.
package l1_arb_pkg;

    localparam int CORE_ADDR_WIDTH = 32;
    localparam int CORE_DATA_WIDTH = 32;
    localparam int CORE_BE_WIDTH   = 4;
    localparam int L1_LINE_SIZE    = 128;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                       src;
        logic                       nc;
        logic                       we;
        logic [CORE_ADDR_WIDTH-1:0] addr;
        logic [CORE_DATA_WIDTH-1:0] wdata;
        logic [CORE_BE_WIDTH-1:0]   be;
    } l1_req_t;

    // Instruction fetches are always cacheable line reads.
    function automatic l1_req_t make_i_req(input logic [CORE_ADDR_WIDTH-1:0] addr);
        l1_req_t r;
        r       = '0;
        r.src   = SRC_I;
        r.addr  = addr;
        return r;
    endfunction

endpackage

// File: rtl/l1_arb_pick.sv
// Grant decision between L1I and L1D. Default: D priority with an I starvation counter.
// With L1_ARB_RR_EN defined: strict round-robin keyed on the last granted source.
module l1_arb_pick
    import l1_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic i_val_i,
    input  logic d_val_i,
    input  logic grant_en_i,
    output logic grant_src_o
);

`ifdef L1_ARB_RR_EN
    logic rr_last_q;

    always_comb begin
        if (i_val_i && d_val_i) begin
            grant_src_o = ~rr_last_q;
        end else if (d_val_i) begin
            grant_src_o = SRC_D;
        end else begin
            grant_src_o = SRC_I;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rr_last_q <= SRC_D;
        end else if (grant_en_i) begin
            rr_last_q <= grant_src_o;
        end
    end
`else
    localparam int              CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          i_forced;

    assign i_forced = i_val_i && (starve_cnt_q == CNT_MAX);

    always_comb begin
        grant_src_o  = (d_val_i && !i_forced) ? SRC_D : SRC_I;
        starve_cnt_d = starve_cnt_q;
        if (grant_en_i) begin
            if (grant_src_o == SRC_I) begin
                starve_cnt_d = '0;
            end else if (i_val_i && (starve_cnt_q != CNT_MAX)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

endmodule

// File: rtl/l1_req_arb.sv
// Single-outstanding arbiter sharing the L1 memory-access path between L1I and L1D.
// Arbitration policy selected by L1_ARB_RR_EN (see l1_arb_pick).
module l1_req_arb
    import l1_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        l1i_req_val,
    input  logic [CORE_ADDR_WIDTH-1:0]  l1i_req_addr,
    output logic                        l1i_req_ack,
    output logic [L1_LINE_SIZE-1:0]     l1i_ack_data,
    input  logic                        l1d_req_val,
    input  logic                        l1d_req_nc,
    input  logic                        l1d_req_we,
    input  logic [CORE_ADDR_WIDTH-1:0]  l1d_req_addr,
    input  logic [CORE_DATA_WIDTH-1:0]  l1d_req_wdata,
    input  logic [CORE_BE_WIDTH-1:0]    l1d_req_be,
    output logic                        l1d_req_ack,
    output logic [L1_LINE_SIZE-1:0]     l1d_ack_data,
    output logic                        mau_req_val,
    input  logic                        mau_req_rdy,
    output logic                        mau_req_src,
    output logic                        mau_req_nc,
    output logic                        mau_req_we,
    output logic [CORE_ADDR_WIDTH-1:0]  mau_req_addr,
    output logic [CORE_DATA_WIDTH-1:0]  mau_req_wdata,
    output logic [CORE_BE_WIDTH-1:0]    mau_req_be,
    input  logic                        mau_ack,
    input  logic [L1_LINE_SIZE-1:0]     mau_ack_data
);

    arb_state_t                 state_q, state_d;
    l1_req_t                    req_q, req_d;
    logic [L1_LINE_SIZE-1:0]    line_q, line_d;
    logic                       grant_en;
    logic                       grant_src;

    assign grant_en = (state_q == ARB_IDLE) && (l1i_req_val || l1d_req_val);

    l1_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk_i       (wb_clk_i),
        .srst_i      (wb_rst_i),
        .i_val_i     (l1i_req_val),
        .d_val_i     (l1d_req_val),
        .grant_en_i  (grant_en),
        .grant_src_o (grant_src)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        line_d  = line_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_en) begin
                    if (grant_src == SRC_D) begin
                        req_d = '{src: SRC_D, nc: l1d_req_nc, we: l1d_req_we,
                                  addr: l1d_req_addr, wdata: l1d_req_wdata, be: l1d_req_be};
                    end else begin
                        req_d = make_i_req(l1i_req_addr);
                    end
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mau_req_rdy) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mau_ack) begin
                    line_d  = mau_ack_data;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ARB_IDLE;
            req_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            line_q  <= line_d;
        end
    end

    assign mau_req_val   = (state_q == ARB_ISSUE);
    assign mau_req_src   = req_q.src;
    assign mau_req_nc    = req_q.nc;
    assign mau_req_we    = req_q.we;
    assign mau_req_addr  = req_q.addr;
    assign mau_req_wdata = req_q.wdata;
    assign mau_req_be    = req_q.be;
    assign l1i_req_ack   = (state_q == ARB_RESP) && (req_q.src == SRC_I);
    assign l1d_req_ack   = (state_q == ARB_RESP) && (req_q.src == SRC_D);
    assign l1i_ack_data  = line_q;
    assign l1d_ack_data  = line_q;

`ifndef SYNTHESIS
    // A late ack belonging to a transfer cut off by reset is expected, not stray.
    logic aborted_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            aborted_q <= aborted_q || (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
        end else if (mau_ack || grant_en) begin
            aborted_q <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && !aborted_q) begin
            assert (!(mau_ack && ((state_q == ARB_IDLE) || (state_q == ARB_ISSUE))));
        end
    end
`endif

endmodule

// File: tb/tb_l1_req_arb.sv
// Directed bench for l1_req_arb; the round-robin scenario runs when built with L1_ARB_RR_EN.
module tb_l1_req_arb;
    import l1_arb_pkg::*;

    logic                        wb_clk_i = 1'b0;
    logic                        wb_rst_i;
    logic                        l1i_req_val;
    logic [CORE_ADDR_WIDTH-1:0]  l1i_req_addr;
    logic                        l1i_req_ack;
    logic [L1_LINE_SIZE-1:0]     l1i_ack_data;
    logic                        l1d_req_val;
    logic                        l1d_req_nc;
    logic                        l1d_req_we;
    logic [CORE_ADDR_WIDTH-1:0]  l1d_req_addr;
    logic [CORE_DATA_WIDTH-1:0]  l1d_req_wdata;
    logic [CORE_BE_WIDTH-1:0]    l1d_req_be;
    logic                        l1d_req_ack;
    logic [L1_LINE_SIZE-1:0]     l1d_ack_data;
    logic                        mau_req_val;
    logic                        mau_req_rdy;
    logic                        mau_req_src;
    logic                        mau_req_nc;
    logic                        mau_req_we;
    logic [CORE_ADDR_WIDTH-1:0]  mau_req_addr;
    logic [CORE_DATA_WIDTH-1:0]  mau_req_wdata;
    logic [CORE_BE_WIDTH-1:0]    mau_req_be;
    logic                        mau_ack;
    logic [L1_LINE_SIZE-1:0]     mau_ack_data;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    l1_req_arb #(.STARVE_MAX(4)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .l1i_req_val   (l1i_req_val),
        .l1i_req_addr  (l1i_req_addr),
        .l1i_req_ack   (l1i_req_ack),
        .l1i_ack_data  (l1i_ack_data),
        .l1d_req_val   (l1d_req_val),
        .l1d_req_nc    (l1d_req_nc),
        .l1d_req_we    (l1d_req_we),
        .l1d_req_addr  (l1d_req_addr),
        .l1d_req_wdata (l1d_req_wdata),
        .l1d_req_be    (l1d_req_be),
        .l1d_req_ack   (l1d_req_ack),
        .l1d_ack_data  (l1d_ack_data),
        .mau_req_val   (mau_req_val),
        .mau_req_rdy   (mau_req_rdy),
        .mau_req_src   (mau_req_src),
        .mau_req_nc    (mau_req_nc),
        .mau_req_we    (mau_req_we),
        .mau_req_addr  (mau_req_addr),
        .mau_req_wdata (mau_req_wdata),
        .mau_req_be    (mau_req_be),
        .mau_ack       (mau_ack),
        .mau_ack_data  (mau_ack_data)
    );

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Plays the downstream side of one transaction; returns in the RESP cycle.
    task automatic serve(input logic [L1_LINE_SIZE-1:0] line, output logic src,
                         output logic ack_i, output logic ack_d, output logic ok);
        ok = 1'b0; src = 1'b0; ack_i = 1'b0; ack_d = 1'b0;
        for (int n = 0; n < 20 && !mau_req_val; n++) tick();
        if (mau_req_val) begin
            ok = 1'b1;
            src = mau_req_src;
            mau_req_rdy = 1'b1;
            tick();
            mau_req_rdy = 1'b0;
            tick();
            mau_ack = 1'b1;
            mau_ack_data = line;
            tick();
            mau_ack = 1'b0;
            ack_i = l1i_req_ack;
            ack_d = l1d_req_ack;
        end
    endtask

    task automatic test_reset();
        l1i_req_val = 0; l1i_req_addr = '0;
        l1d_req_val = 0; l1d_req_nc = 0; l1d_req_we = 0;
        l1d_req_addr = '0; l1d_req_wdata = '0; l1d_req_be = '0;
        mau_req_rdy = 0; mau_ack = 0; mau_ack_data = '0;
        wb_rst_i = 1;
        tick(); tick();
        wb_rst_i = 0;
        tick();
        checks++;
        if ({mau_req_val, mau_req_src, mau_req_nc, mau_req_we, mau_req_addr,
             mau_req_wdata, mau_req_be} !== '0) begin
            errors++;
            $display("FAIL reset_mau val=%b src=%b addr=%h required all 0", mau_req_val, mau_req_src, mau_req_addr);
        end
        checks++;
        if ({l1i_req_ack, l1d_req_ack} !== 2'b00) begin
            errors++;
            $display("FAIL reset_acks i=%b d=%b required 0 0", l1i_req_ack, l1d_req_ack);
        end
        checks++;
        if ((l1i_ack_data | l1d_ack_data) !== '0) begin
            errors++;
            $display("FAIL reset_data i=%h d=%h required 0", l1i_ack_data, l1d_ack_data);
        end
        $display("txn reset done");
    endtask

    task automatic test_single_i();
        logic [L1_LINE_SIZE-1:0] line_a;
        line_a = {(L1_LINE_SIZE/8){8'hA5}};
        l1i_req_val = 1; l1i_req_addr = 32'h0000_0100;   // cycle 0
        tick();                                          // cycle 1
        checks++;
        if (mau_req_val !== 1'b1 || mau_req_src !== SRC_I || mau_req_addr !== 32'h100 ||
            mau_req_we !== 1'b0 || mau_req_nc !== 1'b0) begin
            errors++;
            $display("FAIL single_i_issue val=%b src=%b addr=%h we=%b nc=%b required 1 0 100 0 0",
                     mau_req_val, mau_req_src, mau_req_addr, mau_req_we, mau_req_nc);
        end
        tick(); tick();                                  // cycle 3
        mau_req_rdy = 1;
        tick();                                          // cycle 4
        mau_req_rdy = 0;
        checks++;
        if (mau_req_val !== 1'b0) begin
            errors++;
            $display("FAIL single_i_accept val=%b required 0", mau_req_val);
        end
        tick(); tick();                                  // cycle 6
        mau_ack = 1; mau_ack_data = line_a;
        tick();                                          // cycle 7
        mau_ack = 0; mau_ack_data = '0;
        checks++;
        if (l1i_req_ack !== 1'b1 || l1d_req_ack !== 1'b0 || l1i_ack_data !== line_a) begin
            errors++;
            $display("FAIL single_i_ack ack_i=%b ack_d=%b data=%h required 1 0 %h",
                     l1i_req_ack, l1d_req_ack, l1i_ack_data, line_a);
        end
        l1i_req_val = 0;
        tick();                                          // cycle 8
        checks++;
        if (l1i_req_ack !== 1'b0 || l1d_req_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_i_pulse ack_i=%b ack_d=%b required 0 0", l1i_req_ack, l1d_req_ack);
        end
        $display("txn single_i addr=100 done");
    endtask

`ifndef L1_ARB_RR_EN
    task automatic test_both_dprio();
        logic src, ai, ad, ok;
        l1i_req_val = 1; l1i_req_addr = 32'h200;
        l1d_req_val = 1; l1d_req_addr = 32'h300;
        serve({(L1_LINE_SIZE/8){8'h11}}, src, ai, ad, ok);
        checks++;
        if (!ok || src !== SRC_D || ad !== 1'b1 || ai !== 1'b0) begin
            errors++;
            $display("FAIL both_first ok=%b src=%b ack_i=%b ack_d=%b required 1 1 0 1", ok, src, ai, ad);
        end
        l1d_req_val = 0;
        tick();
        serve({(L1_LINE_SIZE/8){8'h22}}, src, ai, ad, ok);
        checks++;
        if (!ok || src !== SRC_I || ai !== 1'b1 || ad !== 1'b0 || l1i_ack_data !== {(L1_LINE_SIZE/8){8'h22}}) begin
            errors++;
            $display("FAIL both_second ok=%b src=%b ack_i=%b ack_d=%b required 1 0 1 0", ok, src, ai, ad);
        end
        l1i_req_val = 0;
        tick();
        $display("txn both_valid grants D then I");
    endtask

    task automatic test_starve();
        logic src, ai, ad, ok;
        logic [5:0] exp_src;
        exp_src = 6'b10_1111;    // k=0..5 : D,D,D,D,I,D
        for (int k = 0; k < 6; k++) begin
            // I re-presents alongside every D request so it is pending at each arbitration.
            l1i_req_val = 1; l1i_req_addr = 32'h400;
            l1d_req_val = 1; l1d_req_addr = 32'h500 + 32'(k);
            serve({(L1_LINE_SIZE/8){8'h33}}, src, ai, ad, ok);
            checks++;
            if (!ok || src !== exp_src[k] || ad !== exp_src[k] || ai !== ~exp_src[k]) begin
                errors++;
                $display("FAIL starve_grant k=%0d ok=%b src=%b ack_i=%b ack_d=%b required src %b",
                         k, ok, src, ai, ad, exp_src[k]);
            end
            if (k == 4) begin
                checks++;
                if (dut.u_pick.starve_cnt_q !== 3'd0) begin
                    errors++;
                    $display("FAIL starve_cnt_clear cnt=%0d required 0", dut.u_pick.starve_cnt_q);
                end
            end
            if (k == 5) begin
                checks++;
                if (dut.u_pick.starve_cnt_q !== 3'd1) begin
                    errors++;
                    $display("FAIL starve_cnt_restart cnt=%0d required 1", dut.u_pick.starve_cnt_q);
                end
            end
            $display("txn starve k=%0d src=%b", k, src);
            l1i_req_val = 0; l1d_req_val = 0;
            tick();
        end
    endtask
`endif

    task automatic test_stall();
        logic [L1_LINE_SIZE-1:0] line_b;
        int bad;
        line_b = {(L1_LINE_SIZE/8){8'h5A}};
        l1d_req_val = 1; l1d_req_nc = 1; l1d_req_we = 1;
        l1d_req_addr = 32'h0000_2468; l1d_req_wdata = 32'h1234_5678; l1d_req_be = 4'hA;
        tick();
        // Inputs move after the grant; the issued fields must not.
        l1d_req_nc = 0; l1d_req_we = 0; l1d_req_addr = 32'hFFFF_0000;
        l1d_req_wdata = 32'h0; l1d_req_be = 4'h5;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (mau_req_val !== 1'b1 || mau_req_src !== SRC_D || mau_req_nc !== 1'b1 ||
                mau_req_we !== 1'b1 || mau_req_addr !== 32'h0000_2468 ||
                mau_req_wdata !== 32'h1234_5678 || mau_req_be !== 4'hA ||
                l1i_req_ack !== 1'b0 || l1d_req_ack !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c=%0d val=%b src=%b nc=%b we=%b addr=%h wdata=%h be=%h required 1 1 1 1 00002468 12345678 a",
                         c, mau_req_val, mau_req_src, mau_req_nc, mau_req_we, mau_req_addr, mau_req_wdata, mau_req_be);
            end
            tick();
        end
        mau_req_rdy = 1;
        tick();
        mau_req_rdy = 0;
        tick();
        mau_ack = 1; mau_ack_data = line_b;
        tick();
        mau_ack = 0; mau_ack_data = '0;
        checks++;
        if (l1d_req_ack !== 1'b1 || l1i_req_ack !== 1'b0 || l1d_ack_data !== line_b) begin
            errors++;
            $display("FAIL stall_ack ack_d=%b ack_i=%b data=%h required 1 0 %h",
                     l1d_req_ack, l1i_req_ack, l1d_ack_data, line_b);
        end
        l1d_req_val = 0; l1d_req_nc = 0; l1d_req_we = 0;
        l1d_req_addr = '0; l1d_req_wdata = '0; l1d_req_be = '0;
        tick();
        $display("txn stall 10 cycles done");
    endtask

    task automatic test_reset_abort();
        int seen;
        l1d_req_val = 1; l1d_req_addr = 32'h40;
        tick();
        mau_req_rdy = 1;
        tick();
        mau_req_rdy = 0;
        checks++;
        if (dut.state_q !== ARB_WAIT) begin
            errors++;
            $display("FAIL abort_in_wait state=%0d required %0d", dut.state_q, ARB_WAIT);
        end
        wb_rst_i = 1; l1d_req_val = 0;
        tick();
        wb_rst_i = 0;
        tick();
        mau_ack = 1; mau_ack_data = {(L1_LINE_SIZE/8){8'hFF}};
        tick();
        mau_ack = 0; mau_ack_data = '0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (l1i_req_ack !== 1'b0 || l1d_req_ack !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_ack ack_cycles=%0d required 0", seen);
        end
        checks++;
        if (dut.state_q !== ARB_IDLE) begin
            errors++;
            $display("FAIL abort_state state=%0d required %0d", dut.state_q, ARB_IDLE);
        end
        checks++;
        if ({mau_req_val, mau_req_src, mau_req_nc, mau_req_we, mau_req_addr, mau_req_wdata,
             mau_req_be, l1i_req_ack, l1d_req_ack} !== '0 || (l1i_ack_data | l1d_ack_data) !== '0) begin
            errors++;
            $display("FAIL abort_outputs val=%b addr=%h data=%h required all 0",
                     mau_req_val, mau_req_addr, l1d_ack_data);
        end
        $display("txn reset_abort done");
    endtask

`ifdef L1_ARB_RR_EN
    task automatic test_rr();
        logic src, ai, ad, ok;
        logic [3:0] exp_src;
        exp_src = 4'b1010;       // k=0..3 : I,D,I,D
        l1i_req_val = 1; l1i_req_addr = 32'h600;
        l1d_req_val = 1; l1d_req_addr = 32'h700;
        for (int k = 0; k < 4; k++) begin
            serve({(L1_LINE_SIZE/8){8'h44}}, src, ai, ad, ok);
            checks++;
            if (!ok || src !== exp_src[k] || ad !== exp_src[k] || ai !== ~exp_src[k]) begin
                errors++;
                $display("FAIL rr_grant k=%0d ok=%b src=%b ack_i=%b ack_d=%b required src %b",
                         k, ok, src, ai, ad, exp_src[k]);
            end
            $display("txn rr k=%0d src=%b", k, src);
            if (ai) l1i_req_val = 0;
            if (ad) l1d_req_val = 0;
            tick();
            tick();
            l1i_req_val = 1; l1d_req_val = 1;
        end
        l1i_req_val = 0; l1d_req_val = 0;
        for (int c = 0; c < 6; c++) begin
            if (mau_req_val) mau_req_rdy = 1;
            if (dut.state_q == ARB_WAIT) mau_ack = 1;
            tick();
            mau_req_rdy = 0; mau_ack = 0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_i();
`ifndef L1_ARB_RR_EN
        test_both_dprio();
        test_starve();
`endif
        test_stall();
        test_reset_abort();
`ifdef L1_ARB_RR_EN
        test_rr();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
